// File: rtl/sap_pkg.sv
// sap_pkg: opcodes, T-state encoding and control-word bit positions for the SAP sequencer
package sap_pkg;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0011;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  // State code doubles as the visible t_state value, so HALT must be 0
  localparam logic [2:0] ST_HALT = 3'd0;
  localparam logic [2:0] ST_T1 = 3'd1;
  localparam logic [2:0] ST_T2 = 3'd2;
  localparam logic [2:0] ST_T3 = 3'd3;
  localparam logic [2:0] ST_T4 = 3'd4;
  localparam logic [2:0] ST_T5 = 3'd5;
  localparam logic [2:0] ST_T6 = 3'd6;
  localparam int CW_W = 13;
  localparam int CW_PC_INC = 0;
  localparam int CW_PC_OUT = 1;
  localparam int CW_MAR_IN = 2;
  localparam int CW_RAM_OUT = 3;
  localparam int CW_RAM_IN = 4;
  localparam int CW_IR_IN = 5;
  localparam int CW_IR_OUT = 6;
  localparam int CW_A_IN = 7;
  localparam int CW_A_OUT = 8;
  localparam int CW_B_IN = 9;
  localparam int CW_ALU_SUB = 10;
  localparam int CW_ALU_OUT = 11;
  localparam int CW_OUT_IN = 12;
  typedef logic [CW_W-1:0] cw_t;
  function automatic cw_t bit_of(input int i);
    bit_of = cw_t'(1) << i;
  endfunction
endpackage

// File: rtl/sap_if.sv
// sap_if: link between the instruction decode and the T-state register
interface sap_if;
  logic run;
  logic last;
  logic hlt;
  logic [2:0] state;
  modport master(output run, last, hlt, input state);
  modport slave(input run, last, hlt, output state);
endinterface

// File: rtl/sap_ring_counter.sv
// sap_ring_counter: T-state register with freeze, early return to T1 and halt entry
module sap_ring_counter
  import sap_pkg::*;
(
  input logic clock,
  input logic reset,
  sap_if.slave seq
);
  logic [2:0] state_q, state_d;
  always_comb
    state_d = reset ? ST_T1
            : (!seq.run || state_q == ST_HALT) ? state_q
            : seq.hlt ? ST_HALT
            : seq.last ? ST_T1
            : state_q + 3'd1;
  always_ff @(posedge clock) state_q <= state_d;
  assign seq.state = state_q;
endmodule

// File: rtl/sap_controller.sv
// sap_controller: SAP-1 micro-sequencer; define SAP_STA_EN to decode opcode 0011 as STA
module sap_controller
  import sap_pkg::*;
#(
  parameter int SKIP_IDLE_T = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ram_in,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       out_in,
  output logic [2:0] t_state,
  output logic       halted,
  output logic       instr_done
);
`ifdef SAP_STA_EN
  localparam logic STA_EN = 1'b1;
`else
  localparam logic STA_EN = 1'b0;
`endif
  sap_if seq();
  logic [2:0] state;
  logic is_lda, is_add, is_sub, is_sta, is_out, is_hlt, is_nop, alu_op, mem_op, skip_last, last;
  cw_t cw, ctrl;
  assign state = seq.state;
  assign is_lda = opcode == OP_LDA;
  assign is_add = opcode == OP_ADD;
  assign is_sub = opcode == OP_SUB;
  assign is_sta = STA_EN && opcode == OP_STA;
  assign is_out = opcode == OP_OUT;
  assign is_hlt = opcode == OP_HLT;
  assign alu_op = is_add | is_sub;
  assign mem_op = is_lda | alu_op | is_sta;
  assign is_nop = !(mem_op | is_out | is_hlt);
  assign skip_last = (state == ST_T5 && (is_lda || is_sta)) || (state == ST_T4 && (is_out || is_nop));
  assign last = state == ST_T6 || (SKIP_IDLE_T != 0 && skip_last);
  assign seq.run = run;
  assign seq.last = last;
  assign seq.hlt = state == ST_T4 && is_hlt;
  sap_ring_counter u_ring (.clock(clock), .reset(reset), .seq(seq));
  always_comb begin
    cw = '0;
    case (state)
      ST_T1: cw = bit_of(CW_PC_OUT) | bit_of(CW_MAR_IN);
      ST_T2: cw = bit_of(CW_PC_INC);
      ST_T3: cw = bit_of(CW_RAM_OUT) | bit_of(CW_IR_IN);
      ST_T4: cw = mem_op ? bit_of(CW_IR_OUT) | bit_of(CW_MAR_IN)
                : is_out ? bit_of(CW_A_OUT) | bit_of(CW_OUT_IN) : '0;
      ST_T5: cw = is_lda ? bit_of(CW_RAM_OUT) | bit_of(CW_A_IN)
                : alu_op ? bit_of(CW_RAM_OUT) | bit_of(CW_B_IN) | (is_sub ? bit_of(CW_ALU_SUB) : '0)
                : is_sta ? bit_of(CW_A_OUT) | bit_of(CW_RAM_IN) : '0;
      ST_T6: cw = alu_op ? bit_of(CW_ALU_OUT) | bit_of(CW_A_IN) | (is_sub ? bit_of(CW_ALU_SUB) : '0) : '0;
      default: cw = '0;
    endcase
  end
  assign ctrl = (reset || !run) ? '0 : cw;
  assign pc_inc = ctrl[CW_PC_INC];
  assign pc_out = ctrl[CW_PC_OUT];
  assign mar_in = ctrl[CW_MAR_IN];
  assign ram_out = ctrl[CW_RAM_OUT];
  assign ram_in = ctrl[CW_RAM_IN];
  assign ir_in = ctrl[CW_IR_IN];
  assign ir_out = ctrl[CW_IR_OUT];
  assign a_in = ctrl[CW_A_IN];
  assign a_out = ctrl[CW_A_OUT];
  assign b_in = ctrl[CW_B_IN];
  assign alu_sub = ctrl[CW_ALU_SUB];
  assign alu_out = ctrl[CW_ALU_OUT];
  assign out_in = ctrl[CW_OUT_IN];
  assign t_state = state;
  assign halted = !reset && state == ST_HALT;
  assign instr_done = !reset && run && (last || seq.hlt);
endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller: vector table, corner sequences and a random instruction stream vs a micro-step model
module tb_sap_controller;
  localparam logic [12:0] M_PC_INC = 13'd1 << 12;
  localparam logic [12:0] M_PC_OUT = 13'd1 << 11;
  localparam logic [12:0] M_MAR_IN = 13'd1 << 10;
  localparam logic [12:0] M_RAM_OUT = 13'd1 << 9;
  localparam logic [12:0] M_RAM_IN = 13'd1 << 8;
  localparam logic [12:0] M_IR_IN = 13'd1 << 7;
  localparam logic [12:0] M_IR_OUT = 13'd1 << 6;
  localparam logic [12:0] M_A_IN = 13'd1 << 5;
  localparam logic [12:0] M_A_OUT = 13'd1 << 4;
  localparam logic [12:0] M_B_IN = 13'd1 << 3;
  localparam logic [12:0] M_ALU_SUB = 13'd1 << 2;
  localparam logic [12:0] M_ALU_OUT = 13'd1 << 1;
  localparam logic [12:0] M_OUT_IN = 13'd1;
  localparam logic [12:0] FETCH1 = M_PC_OUT | M_MAR_IN;
  localparam logic [12:0] FETCH3 = M_RAM_OUT | M_IR_IN;
  localparam logic [12:0] ADDR = M_IR_OUT | M_MAR_IN;
`ifdef SAP_STA_EN
  localparam bit STA_EN = 1'b1;
`else
  localparam bit STA_EN = 1'b0;
`endif

  typedef struct {
    bit rst;
    bit dut;
    logic [3:0] op;
    logic [12:0] cw;
    logic [2:0] t;
    bit done;
  } vec_t;

  logic clock = 1'b0, reset = 1'b1, run0 = 1'b0, run1 = 1'b0;
  logic [3:0] op0 = 4'd0, op1 = 4'd0;
  logic [12:0] cw0, cw1;
  logic [2:0] t0, t1;
  logic h0, h1, d0, d1;
  int checks = 0, errors = 0;
  vec_t vecs[$];

  always #5 clock = ~clock;

  sap_if mon();
  assign mon.run = run0;
  assign mon.last = d0;
  assign mon.hlt = h0;
  assign mon.state = t0;

  sap_controller #(.SKIP_IDLE_T(0)) dut0 (
    .clock(clock), .reset(reset), .run(run0), .opcode(op0),
    .pc_inc(cw0[12]), .pc_out(cw0[11]), .mar_in(cw0[10]), .ram_out(cw0[9]), .ram_in(cw0[8]),
    .ir_in(cw0[7]), .ir_out(cw0[6]), .a_in(cw0[5]), .a_out(cw0[4]), .b_in(cw0[3]),
    .alu_sub(cw0[2]), .alu_out(cw0[1]), .out_in(cw0[0]),
    .t_state(t0), .halted(h0), .instr_done(d0));

  sap_controller #(.SKIP_IDLE_T(1)) dut1 (
    .clock(clock), .reset(reset), .run(run1), .opcode(op1),
    .pc_inc(cw1[12]), .pc_out(cw1[11]), .mar_in(cw1[10]), .ram_out(cw1[9]), .ram_in(cw1[8]),
    .ir_in(cw1[7]), .ir_out(cw1[6]), .a_in(cw1[5]), .a_out(cw1[4]), .b_in(cw1[3]),
    .alu_sub(cw1[2]), .alu_out(cw1[1]), .out_in(cw1[0]),
    .t_state(t1), .halted(h1), .instr_done(d1));

  // Micro-step table per opcode, read straight off the instruction set description
  function automatic logic [12:0] exp_cw(input logic [3:0] op, input int t);
    bit sta = STA_EN && op == 4'b0011;
    bit mem = op == 4'b0000 || op == 4'b0001 || op == 4'b0010 || sta;
    case (t)
      1: return FETCH1;
      2: return M_PC_INC;
      3: return FETCH3;
      4: return mem ? ADDR : op == 4'b1110 ? (M_A_OUT | M_OUT_IN) : 13'd0;
      5: return op == 4'b0000 ? (M_RAM_OUT | M_A_IN)
              : op == 4'b0001 ? (M_RAM_OUT | M_B_IN)
              : op == 4'b0010 ? (M_RAM_OUT | M_B_IN | M_ALU_SUB)
              : sta ? (M_A_OUT | M_RAM_IN) : 13'd0;
      6: return op == 4'b0001 ? (M_ALU_OUT | M_A_IN)
              : op == 4'b0010 ? (M_ALU_OUT | M_A_IN | M_ALU_SUB) : 13'd0;
      default: return 13'd0;
    endcase
  endfunction

  function automatic int exp_len(input logic [3:0] op, input bit skip);
    if (op == 4'b1111) return 4;
    if (!skip || op == 4'b0001 || op == 4'b0010) return 6;
    if (op == 4'b0000 || (STA_EN && op == 4'b0011)) return 5;
    return 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input string name, input bit dut, input logic [12:0] ecw, input logic [2:0] et,
                     input bit edone, input bit ehalt);
    logic [4:0] bus;
    #1;
    bus = dut ? {cw1[11], cw1[9], cw1[6], cw1[4], cw1[1]} : {cw0[11], cw0[9], cw0[6], cw0[4], cw0[1]};
    chk({name, "/cw"}, dut ? cw1 : cw0, ecw);
    chk({name, "/t"}, dut ? t1 : t0, et);
    chk({name, "/done"}, dut ? d1 : d0, edone);
    chk({name, "/halt"}, dut ? h1 : h0, ehalt);
    checks++;
    assert ($onehot0(bus)) else begin
      errors++;
      $display("FAIL %s/bus_excl: drivers %b expected at most one", name, bus);
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run0 = 1'b0;
    run1 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic add(input bit rst, input bit dut, input logic [3:0] op, input logic [12:0] cw,
                     input logic [2:0] t, input bit done);
    vec_t v;
    v.rst = rst; v.dut = dut; v.op = op; v.cw = cw; v.t = t; v.done = done;
    vecs.push_back(v);
  endtask

  initial begin
    add(1, 0, 4'h0, FETCH1, 1, 0);
    add(0, 0, 4'h0, M_PC_INC, 2, 0);
    add(0, 0, 4'h0, FETCH3, 3, 0);
    add(0, 0, 4'h0, ADDR, 4, 0);
    add(0, 0, 4'h0, M_RAM_OUT | M_A_IN, 5, 0);
    add(0, 0, 4'h0, 13'd0, 6, 1);
    add(0, 0, 4'h0, FETCH1, 1, 0);
    add(1, 0, 4'h2, FETCH1, 1, 0);
    add(0, 0, 4'h2, M_PC_INC, 2, 0);
    add(0, 0, 4'h2, FETCH3, 3, 0);
    add(0, 0, 4'h2, ADDR, 4, 0);
    add(0, 0, 4'h2, M_RAM_OUT | M_B_IN | M_ALU_SUB, 5, 0);
    add(0, 0, 4'h2, M_ALU_OUT | M_A_IN | M_ALU_SUB, 6, 1);
    add(1, 1, 4'hE, FETCH1, 1, 0);
    add(0, 1, 4'hE, M_PC_INC, 2, 0);
    add(0, 1, 4'hE, FETCH3, 3, 0);
    add(0, 1, 4'hE, M_A_OUT | M_OUT_IN, 4, 1);
    add(0, 1, 4'hE, FETCH1, 1, 0);
    add(1, 0, 4'h3, FETCH1, 1, 0);
    add(0, 0, 4'h3, M_PC_INC, 2, 0);
    add(0, 0, 4'h3, FETCH3, 3, 0);
`ifdef SAP_STA_EN
    add(0, 0, 4'h3, ADDR, 4, 0);
    add(0, 0, 4'h3, M_A_OUT | M_RAM_IN, 5, 0);
`else
    add(0, 0, 4'h3, 13'd0, 4, 0);
    add(0, 0, 4'h3, 13'd0, 5, 0);
`endif
    add(0, 0, 4'h3, 13'd0, 6, 1);

    @(negedge clock);
    reset = 1'b0;
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      run0 = !vecs[i].dut;
      run1 = vecs[i].dut;
      if (vecs[i].dut) op1 = vecs[i].op; else op0 = vecs[i].op;
      cyc($sformatf("vec%0d", i), vecs[i].dut, vecs[i].cw, vecs[i].t, vecs[i].done, 0);
    end

    do_reset();
    run0 = 1'b1;
    op0 = 4'hF;
    cyc("hlt_t1", 0, FETCH1, 1, 0, 0);
    cyc("hlt_t2", 0, M_PC_INC, 2, 0, 0);
    cyc("hlt_t3", 0, FETCH3, 3, 0, 0);
    cyc("hlt_t4", 0, 13'd0, 4, 1, 0);
    for (int i = 0; i < 20; i++) cyc("halted", 0, 13'd0, 0, 0, 1);
    chk("mon_state", mon.state, 0);
    reset = 1'b1;
    #1;
    chk("hlt_rst_halted", h0, 0);
    chk("hlt_rst_cw", cw0, 0);
    @(negedge clock);
    reset = 1'b0;
    cyc("hlt_exit", 0, FETCH1, 1, 0, 0);

    do_reset();
    run0 = 1'b1;
    op0 = 4'h1;
    cyc("frz_t1", 0, FETCH1, 1, 0, 0);
    cyc("frz_t2", 0, M_PC_INC, 2, 0, 0);
    cyc("frz_t3", 0, FETCH3, 3, 0, 0);
    cyc("frz_t4", 0, ADDR, 4, 0, 0);
    run0 = 1'b0;
    for (int i = 0; i < 3; i++) cyc("frz_hold", 0, 13'd0, 5, 0, 0);
    run0 = 1'b1;
    cyc("frz_t5", 0, M_RAM_OUT | M_B_IN, 5, 0, 0);
    cyc("frz_t6", 0, M_ALU_OUT | M_A_IN, 6, 1, 0);

    do_reset();
    run0 = 1'b1;
    op0 = 4'h0;
    cyc("rst3_t1", 0, FETCH1, 1, 0, 0);
    cyc("rst3_t2", 0, M_PC_INC, 2, 0, 0);
    reset = 1'b1;
    #1;
    chk("rst3_cw", cw0, 0);
    chk("rst3_done", d0, 0);
    @(negedge clock);
    reset = 1'b0;
    cyc("rst3_after", 0, FETCH1, 1, 0, 0);

    for (int d = 0; d < 2; d++) begin
      do_reset();
      for (int n = 0; n < 500; n++) begin
        logic [3:0] op = 4'($urandom_range(0, 14));
        int len = exp_len(op, d[0]);
        int t = 1;
        while (t <= len) begin
          bit r = $urandom_range(0, 3) != 0;
          logic [3:0] o = t < 4 ? 4'($urandom_range(0, 15)) : op;
          if (d == 0) begin run0 = r; op0 = o; end else begin run1 = r; op1 = o; end
          cyc($sformatf("rnd%0d_n%0d", d, n), d[0], r ? exp_cw(op, t) : 13'd0, 3'(t), r && t == len, 0);
          if (r) t++;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
